// File: rtl/bus_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bus_mon_pkg
// Brief   : Shared types, default sizes and helpers for the bus transaction
//           tracker and its handshake checkers.
// Revision: 1.0 - initial release
// ============================================================================
package bus_mon_pkg;

    localparam int c_def_addr_width = 32;
    localparam int c_def_data_width = 32;
    localparam int c_def_depth      = 4;
    localparam int c_def_timeout    = 256;
    localparam int c_def_cnt_width  = 32;

    // Per-channel stall tracking: IDLE until a beat is offered but not taken.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        STALL = 1'b1
    } stall_state_t;

    // Pointer index width for a DEPTH-entry queue (DEPTH is a power of 2).
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_txn_tracker_if.sv
`default_nettype none
// ============================================================================
// Module  : bus_txn_tracker_if
// Brief   : One valid/ready read channel pair (addr request, data response).
//           master = requester, slave = responder, monitor = passive observer.
// Revision: 1.0 - initial release
// ============================================================================
interface bus_txn_tracker_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  addr_valid;
    logic                  addr_ready;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  data_valid;
    logic                  data_ready;
    logic [DATA_WIDTH-1:0] data;

    modport master (
        output addr_valid, addr, data_ready,
        input  addr_ready, data_valid, data
    );

    modport slave (
        input  addr_valid, addr, data_ready,
        output addr_ready, data_valid, data
    );

    modport monitor (
        input addr_valid, addr_ready, addr,
        input data_valid, data_ready, data
    );
endinterface
`default_nettype wire

// File: rtl/bus_hs_checker.sv
`default_nettype none
// ============================================================================
// Module  : bus_hs_checker
// Brief   : Watches one valid/ready channel. Once a beat stalls (valid without
//           ready) valid and payload must hold until the beat is accepted;
//           any drop or change gives a one-cycle registered err pulse.
// Revision: 1.0 - initial release
// ============================================================================
module bus_hs_checker
    import bus_mon_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         valid,
    input  logic         ready,
    input  logic [W-1:0] payload,
    output logic         err
);

    stall_state_t r_state;
    stall_state_t w_state_nxt;
    logic [W-1:0] r_cap;
    logic [W-1:0] w_cap_nxt;
    logic         w_err_nxt;

    // Next state: open a stall window on valid&!ready, close it on acceptance or violation
    always_comb begin
        w_state_nxt = r_state;
        w_cap_nxt   = r_cap;
        w_err_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (valid && !ready) begin
                    w_state_nxt = STALL;
                    w_cap_nxt   = payload;
                end
            end
            STALL: begin
                // A violation ends the window even if ready arrives in the same cycle.
                if (!valid || (payload != r_cap)) begin
                    w_state_nxt = IDLE;
                    w_err_nxt   = 1'b1;
                end else if (ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, captured payload and registered error pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cap   <= '0;
            err     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cap   <= w_cap_nxt;
            err     <= w_err_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bus_txn_tracker.sv
`default_nettype none
// ============================================================================
// Module  : bus_txn_tracker
// Brief   : Pairs each addr handshake with its in-order data handshake on one
//           read channel pair, reporting addr/data/latency and flagging
//           underflow, overflow, handshake instability and timeout.
// Revision: 1.0 - initial release
// ============================================================================
module bus_txn_tracker
    import bus_mon_pkg::*;
#(
    parameter int ADDR_WIDTH = c_def_addr_width,
    parameter int DATA_WIDTH = c_def_data_width,
    parameter int DEPTH      = c_def_depth,
    parameter int TIMEOUT    = c_def_timeout,
    parameter int CNT_WIDTH  = c_def_cnt_width
) (
    input  logic                    clk,
    input  logic                    rst,
    bus_txn_tracker_if.monitor      bus,
    output logic                    match_valid,
    output logic [ADDR_WIDTH-1:0]   match_addr,
    output logic [DATA_WIDTH-1:0]   match_data,
    output logic [CNT_WIDTH-1:0]    match_latency,
    output logic [$clog2(DEPTH):0]  outstanding,
    output logic [CNT_WIDTH-1:0]    txn_count,
    output logic                    err_underflow,
    output logic                    err_overflow,
    output logic                    err_addr_unstable,
    output logic                    err_data_unstable,
    output logic                    err_timeout
);

    localparam int c_ptr_w = ptr_w(DEPTH);

    // Queue entry; widths follow this instance's parameters, so it lives here.
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [CNT_WIDTH-1:0]  ts;
        logic                  timed_out;
    } entry_t;

    entry_t               r_mem [DEPTH];
    logic [c_ptr_w:0]     r_wr_ptr;
    logic [c_ptr_w:0]     r_rd_ptr;
    logic [CNT_WIDTH-1:0] r_ts;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_push_ok;
    logic                 w_pop_ok;
    logic                 w_underflow;
    logic                 w_overflow;
    logic                 w_timeout;
    logic [c_ptr_w-1:0]   w_wr_idx;
    logic [c_ptr_w-1:0]   w_rd_idx;
    logic [c_ptr_w:0]     w_wr_ptr_nxt;
    logic [c_ptr_w:0]     w_rd_ptr_nxt;
    entry_t               w_head;
    logic [CNT_WIDTH-1:0] w_head_age;

    // Handshake decode, queue status and error conditions for this cycle
    always_comb begin
        w_push     = bus.addr_valid && bus.addr_ready;
        w_pop      = bus.data_valid && bus.data_ready;
        w_wr_idx   = r_wr_ptr[c_ptr_w-1:0];
        w_rd_idx   = r_rd_ptr[c_ptr_w-1:0];
        w_empty    = (r_wr_ptr == r_rd_ptr);
        w_full     = (r_wr_ptr[c_ptr_w] != r_rd_ptr[c_ptr_w]) && (w_wr_idx == w_rd_idx);
        w_head     = r_mem[w_rd_idx];
        w_head_age = r_ts - w_head.ts;

        w_pop_ok    = w_pop && !w_empty;
        w_underflow = w_pop && w_empty;
        // Pop happens first, so a full queue still accepts a push on a pop cycle.
        w_push_ok   = w_push && (!w_full || w_pop_ok);
        w_overflow  = w_push && w_full && !w_pop;

        // Age threshold uses >= so an entry already overdue when it becomes
        // head is still reported; timed_out keeps it to a single pulse.
        // A pop in the threshold cycle is still within the allowed window.
        w_timeout = !w_empty && !w_head.timed_out && !w_pop_ok
                    && (w_head_age >= CNT_WIDTH'(TIMEOUT));

        w_wr_ptr_nxt = r_wr_ptr + {{c_ptr_w{1'b0}}, w_push_ok};
        w_rd_ptr_nxt = r_rd_ptr + {{c_ptr_w{1'b0}}, w_pop_ok};
    end

    // Timestamp, queue storage/pointers and all registered report outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ts     <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            match_valid   <= 1'b0;
            match_addr    <= '0;
            match_data    <= '0;
            match_latency <= '0;
            outstanding   <= '0;
            txn_count     <= '0;
            err_underflow <= 1'b0;
            err_overflow  <= 1'b0;
            err_timeout   <= 1'b0;
        end else begin
            r_ts        <= r_ts + CNT_WIDTH'(1);
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_rd_ptr    <= w_rd_ptr_nxt;
            outstanding <= w_wr_ptr_nxt - w_rd_ptr_nxt;

            if (w_timeout) begin
                r_mem[w_rd_idx].timed_out <= 1'b1;
            end
            if (w_push_ok) begin
                r_mem[w_wr_idx] <= '{addr: bus.addr, ts: r_ts, timed_out: 1'b0};
            end

            match_valid <= w_pop_ok;
            if (w_pop_ok) begin
                match_addr    <= w_head.addr;
                match_data    <= bus.data;
                match_latency <= w_head_age;
                txn_count     <= txn_count + CNT_WIDTH'(1);
            end

            err_underflow <= w_underflow;
            err_overflow  <= w_overflow;
            err_timeout   <= w_timeout;
        end
    end

    bus_hs_checker #(
        .W (ADDR_WIDTH)
    ) u_addr_chk (
        .clk     (clk),
        .rst     (rst),
        .valid   (bus.addr_valid),
        .ready   (bus.addr_ready),
        .payload (bus.addr),
        .err     (err_addr_unstable)
    );

    bus_hs_checker #(
        .W (DATA_WIDTH)
    ) u_data_chk (
        .clk     (clk),
        .rst     (rst),
        .valid   (bus.data_valid),
        .ready   (bus.data_ready),
        .payload (bus.data),
        .err     (err_data_unstable)
    );

endmodule
`default_nettype wire

// File: tb/tb_bus_txn_tracker.sv
`default_nettype none
// ============================================================================
// Module  : tb_bus_txn_tracker
// Brief   : Self-checking bench for bus_txn_tracker: directed scenarios plus
//           randomized traffic against a queue-based reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_bus_txn_tracker;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;
    localparam int CW      = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bus_txn_tracker_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    logic          match_valid;
    logic [AW-1:0] match_addr;
    logic [DW-1:0] match_data;
    logic [CW-1:0] match_latency;
    logic [2:0]    outstanding;
    logic [CW-1:0] txn_count;
    logic          err_underflow;
    logic          err_overflow;
    logic          err_addr_unstable;
    logic          err_data_unstable;
    logic          err_timeout;

    bus_txn_tracker #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .TIMEOUT    (TIMEOUT),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .bus               (bus),
        .match_valid       (match_valid),
        .match_addr        (match_addr),
        .match_data        (match_data),
        .match_latency     (match_latency),
        .outstanding       (outstanding),
        .txn_count         (txn_count),
        .err_underflow     (err_underflow),
        .err_overflow      (err_overflow),
        .err_addr_unstable (err_addr_unstable),
        .err_data_unstable (err_data_unstable),
        .err_timeout       (err_timeout)
    );

    // Reference model state: transaction queue, cycle counter, stall records
    typedef struct {
        logic [AW-1:0] addr;
        logic [CW-1:0] ts;
        bit            timed_out;
    } txn_t;

    txn_t          q[$];
    logic [CW-1:0] m_ts;
    bit            a_hold, d_hold;
    logic [31:0]   a_cap, d_cap;

    logic          e_mv, e_uf, e_of, e_au, e_du, e_to;
    logic [AW-1:0] e_ma;
    logic [DW-1:0] e_md;
    logic [CW-1:0] e_lat, e_cnt;
    int            e_out;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ts   = '0;
        a_hold = 1'b0;
        d_hold = 1'b0;
        a_cap  = '0;
        d_cap  = '0;
        e_mv = 0; e_uf = 0; e_of = 0; e_au = 0; e_du = 0; e_to = 0;
        e_ma = '0; e_md = '0; e_lat = '0; e_cnt = '0; e_out = 0;
    endtask

    // A stalled beat must be offered unchanged until it is accepted.
    function automatic bit stall_violation(inout bit hold, inout logic [31:0] cap,
                                           input logic v, input logic r,
                                           input logic [31:0] p);
        bit viol = 1'b0;
        if (hold) begin
            if (!v || p != cap) begin
                viol = 1'b1;
                hold = 1'b0;
            end else if (r) begin
                hold = 1'b0;
            end
        end else if (v && !r) begin
            hold = 1'b1;
            cap  = p;
        end
        return viol;
    endfunction

    // Expected outputs for the next cycle given the inputs currently driven.
    task automatic model_step();
        bit   push, pop, pop_ok;
        txn_t t;
        push   = bus.addr_valid && bus.addr_ready;
        pop    = bus.data_valid && bus.data_ready;
        pop_ok = pop && (q.size() > 0);

        e_to = 1'b0;
        if (q.size() > 0 && !q[0].timed_out && !pop_ok && (m_ts - q[0].ts) >= CW'(TIMEOUT)) begin
            e_to = 1'b1;
            q[0].timed_out = 1'b1;
        end

        e_mv = 1'b0;
        e_uf = 1'b0;
        if (pop) begin
            if (q.size() == 0) begin
                e_uf = 1'b1;
            end else begin
                t     = q.pop_front();
                e_mv  = 1'b1;
                e_ma  = t.addr;
                e_md  = bus.data;
                e_lat = m_ts - t.ts;
                e_cnt = e_cnt + 1;
            end
        end

        e_of = 1'b0;
        if (push) begin
            if (q.size() < DEPTH) q.push_back('{addr: bus.addr, ts: m_ts, timed_out: 1'b0});
            else                  e_of = 1'b1;
        end
        e_out = q.size();

        e_au = stall_violation(a_hold, a_cap, bus.addr_valid, bus.addr_ready, bus.addr);
        e_du = stall_violation(d_hold, d_cap, bus.data_valid, bus.data_ready, bus.data);
        m_ts = m_ts + 1;
    endtask

    // One clock: predict, let the DUT clock, sample #1 after the edge, compare.
    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check("match_valid",   match_valid,       e_mv);
        check("match_addr",    match_addr,        e_ma);
        check("match_data",    match_data,        e_md);
        check("match_latency", match_latency,     e_lat);
        check("outstanding",   outstanding,       e_out);
        check("txn_count",     txn_count,         e_cnt);
        check("err_underflow", err_underflow,     e_uf);
        check("err_overflow",  err_overflow,      e_of);
        check("err_addr_unst", err_addr_unstable, e_au);
        check("err_data_unst", err_data_unstable, e_du);
        check("err_timeout",   err_timeout,       e_to);
    endtask

    task automatic drive(input logic av, input logic ar, input logic [AW-1:0] a,
                         input logic dv, input logic dr, input logic [DW-1:0] d);
        bus.addr_valid = av;
        bus.addr_ready = ar;
        bus.addr       = a;
        bus.data_valid = dv;
        bus.data_ready = dr;
        bus.data       = d;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        #1;
        check("rst_outstanding", outstanding, 0);
        check("rst_match_valid", match_valid, 0);
        check("rst_txn_count",   txn_count,   0);
        check("rst_errors", {err_underflow, err_overflow, err_addr_unstable,
                             err_data_unstable, err_timeout}, 0);
        check("rst_match_lat",   match_latency, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pulses;
        int pulse_cycle;
        logic          av, ar, dv, dr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;

        rst = 1'b1;
        idle();
        model_reset();
        #2;

        // Basic pairing: addr 0x100 at cycle 10, data at cycle 13.
        do_reset();
        while (m_ts != 10) begin idle(); step(); end
        drive(1'b1, 1'b1, 32'h100, 1'b0, 1'b0, '0); step();
        while (m_ts != 13) begin idle(); step(); end
        drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 32'hDEADBEEF); step();
        check("t1_match_valid", match_valid, 1);
        check("t1_match_addr",  match_addr,  32'h100);
        check("t1_match_data",  match_data,  32'hDEADBEEF);
        check("t1_latency",     match_latency, 3);
        check("t1_txn_count",   txn_count, 1);
        idle(); step();
        check("t1_pulse_end", match_valid, 0);

        // Overflow: four addrs fill the queue, fifth is dropped.
        do_reset();
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 32'(i * 4), 1'b0, 1'b0, '0); step();
            if (err_overflow) pulses++;
        end
        check("ovf_flag",        err_overflow, 1);
        check("ovf_outstanding", outstanding, 4);
        check("ovf_pulses",      pulses, 1);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 32'hA0 + 32'(i)); step();
            check("ovf_pop_addr", match_addr, 32'(i * 4));
        end
        check("ovf_drained", outstanding, 0);

        // Underflow: data handshake with nothing queued.
        do_reset();
        drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 32'h55); step();
        check("uf_flag",        err_underflow, 1);
        check("uf_match_valid", match_valid, 0);
        check("uf_outstanding", outstanding, 0);
        idle(); step();
        check("uf_one_cycle", err_underflow, 0);

        // Addr payload changes while stalled: exactly one pulse.
        do_reset();
        pulses = 0;
        drive(1'b1, 1'b0, 32'h10, 1'b0, 1'b0, '0); step(); if (err_addr_unstable) pulses++;
        drive(1'b1, 1'b0, 32'h10, 1'b0, 1'b0, '0); step(); if (err_addr_unstable) pulses++;
        drive(1'b1, 1'b0, 32'h14, 1'b0, 1'b0, '0); step(); if (err_addr_unstable) pulses++;
        for (int i = 0; i < 3; i++) begin idle(); step(); if (err_addr_unstable) pulses++; end
        check("unst_pulses", pulses, 1);

        // Timeout: addr at cycle 0, flag visible at cycle 9 only, data at 20.
        do_reset();
        pulses      = 0;
        pulse_cycle = -1;
        drive(1'b1, 1'b1, 32'h200, 1'b0, 1'b0, '0); step();
        while (m_ts != 20) begin
            idle(); step();
            if (err_timeout) begin pulses++; pulse_cycle = int'(m_ts); end
        end
        check("to_pulses", pulses, 1);
        check("to_cycle",  pulse_cycle, 9);
        drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 32'h77); step();
        check("to_match_valid", match_valid, 1);
        check("to_latency",     match_latency, 20);

        // Reset with two entries queued drops them.
        do_reset();
        drive(1'b1, 1'b1, 32'h300, 1'b0, 1'b0, '0); step();
        drive(1'b1, 1'b1, 32'h304, 1'b0, 1'b0, '0); step();
        check("rq_queued", outstanding, 2);
        do_reset();
        drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 32'h99); step();
        check("rq_underflow", err_underflow, 1);
        check("rq_no_match",  match_valid, 0);

        // Randomized traffic, mostly well-behaved with occasional stall violations.
        do_reset();
        av = 0; ar = 0; a = '0; dv = 0; dr = 0; d = '0;
        for (int i = 0; i < 400; i++) begin
            if (av && !ar && ($urandom_range(0, 9) != 0)) begin
                ar = ($urandom_range(0, 1) == 1);
            end else begin
                av = ($urandom_range(0, 9) < 6);
                ar = ($urandom_range(0, 1) == 1);
                a  = $urandom;
            end
            if (dv && !dr && ($urandom_range(0, 9) != 0)) begin
                dr = ($urandom_range(0, 1) == 1);
            end else begin
                dv = ($urandom_range(0, 9) < 5);
                dr = ($urandom_range(0, 1) == 1);
                d  = $urandom;
            end
            drive(av, ar, a, dv, dr, d);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
